// File: rtl/core_pkg.sv
// Shared core sizing and packet type for the rename-to-issue path.
package core_pkg;

  localparam int unsigned PACKET_W       = 223;
  localparam int unsigned DISPATCH_DEPTH = 4;

  typedef logic [PACKET_W-1:0] packet_t;

endpackage

// File: rtl/queue_entry_reg.sv
// One packet-wide storage row: loads d when enable is high, clears on reset.
module queue_entry_reg #(
  parameter int unsigned WIDTH = 223
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between decode and issue: pointer/occupancy control,
// write-enable decode into the entry rows, and the combinational head read mux.
module dispatch_queue
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = PACKET_W,
  parameter int unsigned DEPTH = DISPATCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;
  logic [DEPTH-1:0] row_we;
  logic [WIDTH-1:0] rows [DEPTH];

  assign in_ready  = ~full_q;
  assign out_valid = ~empty_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next pointer/occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Full/empty are registered alongside count so the handshakes come straight off flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    assign row_we[i] = push & ~flush & (wr_ptr_q == PTR_W'(i));

    queue_entry_reg #(
      .WIDTH (WIDTH)
    ) u_row (
      .clk    (clk),
      .reset  (reset),
      .enable (row_we[i]),
      .d      (in_data),
      .q      (rows[i])
    );
  end

  assign out_data = rows[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
